registro_umbrales: RTL and testbench

- Downstream stage of the key-validation block in the PS/2 keypad path.
- Consumes the validated key stream: the parameter selects tempenable/humoenable plus the 4-bit code cor.
- Assembles up to two BCD digits per entry and commits them on ENTER into one of two alarm-threshold registers (temperature, smoke).
- Exposes the thresholds and the in-progress entry to the comparator and display logic.

---
 rtl/registro_umbrales_pkg.sv | 22 ++
 rtl/registro_umbrales_if.sv | 27 ++
 rtl/registro_umbrales_temporizador_edicion.sv | 37 +++
 rtl/registro_umbrales.sv | 131 +++++++++++++
 tb/tb_registro_umbrales.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/registro_umbrales_pkg.sv
// Shared key codes, FSM encoding and default alarm thresholds for the keypad threshold path.
// Also used by the comparator and display blocks.
package registro_umbrales_pkg;

    localparam logic [3:0] TECLA_ENTER = 4'hA;
    localparam logic [3:0] TECLA_CLEAR = 4'hB;

    localparam logic [7:0] UMBRAL_TEMP_DEF = 8'h30;
    localparam logic [7:0] UMBRAL_HUMO_DEF = 8'h50;
    localparam logic [7:0] TEMP_MAX_DEF    = 8'h85;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } estado_t;

    function automatic logic es_digito(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/registro_umbrales_if.sv
// Validated key stream in, committed thresholds and entry status out.
// master drives keys (key-validation stage), slave is the threshold register.
interface registro_umbrales_if;

    logic       tecla_valida;
    logic       tempenable;
    logic       humoenable;
    logic [3:0] cor;
    logic [7:0] umbral_temp;
    logic [7:0] umbral_humo;
    logic [7:0] pendiente;
    logic       editando;
    logic       sel_humo;
    logic       actualizado;
    logic       error;

    modport master (
        output tecla_valida, tempenable, humoenable, cor,
        input  umbral_temp, umbral_humo, pendiente, editando, sel_humo, actualizado, error
    );

    modport slave (
        input  tecla_valida, tempenable, humoenable, cor,
        output umbral_temp, umbral_humo, pendiente, editando, sel_humo, actualizado, error
    );

endinterface

// File: rtl/registro_umbrales_temporizador_edicion.sv
// Idle timer for an open entry; expira is combinational from the count register.
// No backpressure: counts every enabled cycle, clr has priority over en.
module temporizador_edicion #(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expira
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expira = en && (cnt_q == LIMITE);

endmodule

// File: rtl/registro_umbrales.sv
// Assembles up to two BCD digits per entry and commits them to the temperature or smoke threshold.
// Latency 1 cycle from the tecla_valida strobe; no backpressure, every strobe is consumed.
module registro_umbrales
    import registro_umbrales_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
    parameter int unsigned CNT_W          = 26,
    parameter logic [7:0]  DEF_TEMP       = UMBRAL_TEMP_DEF,
    parameter logic [7:0]  DEF_HUMO       = UMBRAL_HUMO_DEF,
    parameter logic [7:0]  MAX_TEMP       = TEMP_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    registro_umbrales_if.slave  bus
);

    estado_t    estado_q, estado_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] temp_q, temp_d;
    logic [7:0] humo_q, humo_d;
    logic       sel_q, sel_d;
    logic       act_q, act_d;
    logic       err_q, err_d;

    logic es_dig, es_enter, es_clear, tecla_usada, expira, timeout;

    assign es_dig      = es_digito(bus.cor);
    assign es_enter    = (bus.cor == TECLA_ENTER);
    assign es_clear    = (bus.cor == TECLA_CLEAR);
    // Codes C-F are invisible: they neither act nor restart the idle timer.
    assign tecla_usada = bus.tecla_valida && (es_dig || es_enter || es_clear);
    assign timeout     = expira && !tecla_usada;

    always_comb begin
        estado_d = estado_q;
        pend_d   = pend_q;
        temp_d   = temp_q;
        humo_d   = humo_q;
        sel_d    = sel_q;
        act_d    = 1'b0;
        err_d    = 1'b0;
        if (timeout) begin
            estado_d = IDLE;
            pend_d   = '0;
            err_d    = 1'b1;
        end else if (tecla_usada) begin
            unique case (estado_q)
                IDLE: begin
                    if (es_dig) begin
                        if (bus.tempenable ^ bus.humoenable) begin
                            pend_d   = {4'h0, bus.cor};
                            sel_d    = bus.humoenable;
                            estado_d = DIG1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                DIG1, DIG2: begin
                    if (es_dig) begin
                        if (estado_q == DIG1) begin
                            pend_d   = {pend_q[3:0], bus.cor};
                            estado_d = DIG2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        estado_d = IDLE;
                        pend_d   = '0;
                        // Valid BCD orders the same as binary, so a plain compare suffices.
                        if (es_enter) begin
                            if (!sel_q && (pend_q > MAX_TEMP)) begin
                                err_d = 1'b1;
                            end else if (sel_q) begin
                                humo_d = pend_q;
                                act_d  = 1'b1;
                            end else begin
                                temp_d = pend_q;
                                act_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    estado_d = IDLE;
                    pend_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            pend_q   <= '0;
            temp_q   <= DEF_TEMP;
            humo_q   <= DEF_HUMO;
            sel_q    <= 1'b0;
            act_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            temp_q   <= temp_d;
            humo_q   <= humo_d;
            sel_q    <= sel_d;
            act_q    <= act_d;
            err_q    <= err_d;
        end
    end

    temporizador_edicion #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .CNT_W          (CNT_W)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clr    (tecla_usada || (estado_d == IDLE)),
        .en     (estado_q != IDLE),
        .expira (expira)
    );

    assign bus.umbral_temp = temp_q;
    assign bus.umbral_humo = humo_q;
    assign bus.pendiente   = pend_q;
    assign bus.editando    = (estado_q != IDLE);
    assign bus.sel_humo    = sel_q;
    assign bus.actualizado = act_q;
    assign bus.error       = err_q;

endmodule

// File: tb/tb_registro_umbrales.sv
// Bench for registro_umbrales: directed plan followed by random keys against a decimal-value model.
module tb_registro_umbrales;

    localparam int T = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    registro_umbrales_if bus();

    registro_umbrales #(
        .TIMEOUT_CICLOS (T),
        .CNT_W          (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: entry is a list of decimal digits, thresholds are plain integers.
    bit m_abierta;
    bit m_sel;
    bit m_act;
    bit m_err;
    int m_temp;
    int m_humo;
    int m_espera;
    int dig[$];

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int valor_entrada();
        int v = 0;
        foreach (dig[i]) v = v * 10 + dig[i];
        return v;
    endfunction

    task automatic m_reset();
        m_abierta = 0; m_sel = 0; m_act = 0; m_err = 0;
        m_temp = 30; m_humo = 50; m_espera = 0;
        dig.delete();
    endtask

    task automatic modelo(input bit v, input bit te, input bit he, input int c);
        bit usada;
        int val;
        usada = v && (c <= 9 || c == 10 || c == 11);
        m_act = 0;
        m_err = 0;
        if (usada) begin
            m_espera = 0;
            if (!m_abierta) begin
                if (c <= 9) begin
                    if (te != he) begin
                        m_abierta = 1; m_sel = he; dig.delete(); dig.push_back(c);
                    end else m_err = 1;
                end
            end else if (c <= 9) begin
                if (dig.size() == 2) m_err = 1;
                else dig.push_back(c);
            end else begin
                if (c == 10) begin
                    val = valor_entrada();
                    if (!m_sel && val > 85) m_err = 1;
                    else begin
                        if (m_sel) m_humo = val; else m_temp = val;
                        m_act = 1;
                    end
                end
                m_abierta = 0;
                dig.delete();
            end
        end else if (m_abierta) begin
            if (m_espera == T - 1) begin
                m_err = 1; m_abierta = 0; dig.delete(); m_espera = 0;
            end else m_espera++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_modelo();
        chk("umbral_temp", bus.umbral_temp, bcd(m_temp));
        chk("umbral_humo", bus.umbral_humo, bcd(m_humo));
        chk("pendiente",   bus.pendiente,   m_abierta ? bcd(valor_entrada()) : 8'h00);
        chk("editando",    {7'b0, bus.editando},    {7'b0, m_abierta});
        chk("sel_humo",    {7'b0, bus.sel_humo},    {7'b0, m_sel});
        chk("actualizado", {7'b0, bus.actualizado}, {7'b0, m_act});
        chk("error",       {7'b0, bus.error},       {7'b0, m_err});
    endtask

    task automatic paso(input bit v, input bit te, input bit he, input int c);
        bus.tecla_valida = v;
        bus.tempenable   = te;
        bus.humoenable   = he;
        bus.cor          = 4'(c);
        @(posedge clk);
        modelo(v, te, he, c);
        #1;
        chk_modelo();
    endtask

    task automatic inactivo(input int n);
        for (int i = 0; i < n; i++) paso(0, 0, 0, 0);
    endtask

    initial begin
        int r, c;
        bit te, he, v;
        reset = 1'b0;
        bus.tecla_valida = 0; bus.tempenable = 0; bus.humoenable = 0; bus.cor = 4'h0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_modelo();
        chk("rst_temp", bus.umbral_temp, 8'h30);
        chk("rst_humo", bus.umbral_humo, 8'h50);
        reset = 1'b1;

        paso(1, 1, 0, 4);   chk("pend_4", bus.pendiente, 8'h04);
        paso(1, 1, 0, 2);   chk("pend_42", bus.pendiente, 8'h42);
        paso(1, 1, 0, 10);  chk("temp_42", bus.umbral_temp, 8'h42);
        chk("act_pulse", {7'b0, bus.actualizado}, 8'h01);
        paso(0, 0, 0, 0);   chk("act_one_cycle", {7'b0, bus.actualizado}, 8'h00);

        paso(1, 0, 1, 7); paso(1, 0, 1, 5);
        paso(1, 0, 1, 3);   chk("third_dig_err", {7'b0, bus.error}, 8'h01);
        chk("pend_75", bus.pendiente, 8'h75);
        paso(1, 0, 1, 10);  chk("humo_75", bus.umbral_humo, 8'h75);

        paso(1, 1, 0, 9); paso(1, 1, 0, 0);
        paso(1, 1, 0, 10);  chk("temp_90_err", {7'b0, bus.error}, 8'h01);
        chk("temp_unchanged", bus.umbral_temp, 8'h42);
        chk("idle_after_rej", {7'b0, bus.editando}, 8'h00);

        paso(1, 1, 1, 6);   chk("both_en_err", {7'b0, bus.error}, 8'h01);
        paso(1, 0, 1, 6);
        inactivo(T - 1);    chk("pre_timeout", {7'b0, bus.editando}, 8'h01);
        inactivo(1);        chk("timeout_err", {7'b0, bus.error}, 8'h01);
        chk("timeout_humo", bus.umbral_humo, 8'h75);

        paso(1, 0, 1, 6);
        inactivo(T - 1);
        paso(1, 0, 1, 1);   chk("expiry_strobe", bus.pendiente, 8'h61);
        chk("expiry_no_err", {7'b0, bus.error}, 8'h00);
        paso(1, 0, 1, 10);  chk("humo_61", bus.umbral_humo, 8'h61);

        paso(1, 1, 0, 1); paso(1, 1, 0, 2);
        bus.tecla_valida = 0;
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("async_edit", {7'b0, bus.editando}, 8'h00);
        chk("async_temp", bus.umbral_temp, 8'h30);
        chk("async_humo", bus.umbral_humo, 8'h50);
        chk("async_pend", bus.pendiente, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                inactivo(T + 2);
            end else begin
                v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 7);
                te = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
                he = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : !r[0];
                r = $urandom_range(0, 11);
                c = (r < 8) ? $urandom_range(0, 9) : (r < 10) ? 10 : (r == 10) ? 11 : $urandom_range(12, 15);
                paso(v, te, he, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
